// File: rtl/host_monitor.sv
// ============================================================================
// Module   : host_monitor
// Purpose  : Multi-port tohost store snooper with sticky pass/fail status and
//            an optional cycle watchdog (build with HOST_MONITOR_WATCHDOG_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module host_monitor #(
   parameter int          PORTS     = 1,
   parameter logic [31:0] HOST_ADDR = 32'h0,
   parameter int          SRC_W     = (PORTS > 1) ? $clog2(PORTS) : 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 clear,
   input  logic [31:0]          stop_limit,
   input  logic [PORTS-1:0]     mem_valid,
   input  logic [PORTS-1:0]     mem_ready,
   input  logic [PORTS*32-1:0]  mem_addr,
   input  logic [PORTS*32-1:0]  mem_wdata,
   input  logic [PORTS*4-1:0]   mem_wstrb,
   output logic                 done,
   output logic                 pass,
   output logic                 timeout,
   output logic [30:0]          code,
   output logic [SRC_W-1:0]     src,
   output logic [31:0]          cycles
);

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
`ifdef HOST_MONITOR_WATCHDOG_EN
      S_TIMEOUT = 2'd2,
`endif
      S_DONE    = 2'd1
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               r_done;
   logic               r_pass;
   logic               r_timeout;
   logic [30:0]        r_code;
   logic [SRC_W-1:0]   r_src;
   logic [31:0]        r_cycles;

   logic [PORTS-1:0]   w_hit;
   logic [31:0]        w_val [PORTS];
   logic [2*PORTS-1:0] w_unused_lsb;
   logic               w_any;
   logic [SRC_W-1:0]   w_idx;
   logic [31:0]        w_sel;
   logic               w_capture;
   logic               w_fire;

   // Per-port hit detect; disabled byte lanes read back as zero.
   for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
      logic [29:0] w_addr_hi;
      logic [31:0] w_data;
      logic [3:0]  w_strb;
      assign w_addr_hi = mem_addr[32*gi+2 +: 30];
      assign w_data    = mem_wdata[32*gi +: 32];
      assign w_strb    = mem_wstrb[4*gi +: 4];
      assign w_unused_lsb[2*gi +: 2] = mem_addr[32*gi +: 2];
      assign w_hit[gi] = mem_valid[gi] & mem_ready[gi] &
                         (w_addr_hi == HOST_ADDR[31:2]) & (|w_strb);
      assign w_val[gi] = w_data & {{8{w_strb[3]}}, {8{w_strb[2]}},
                                   {8{w_strb[1]}}, {8{w_strb[0]}}};
   end

`ifndef HOST_MONITOR_WATCHDOG_EN
   logic w_unused_limit;
   assign w_unused_limit = ^stop_limit;
`endif

   // Descending scan so the lowest hitting port is the one left selected.
   always_comb begin
      w_any = 1'b0;
      w_idx = '0;
      w_sel = 32'h0;
      for (int i = PORTS - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_any = 1'b1;
            w_idx = SRC_W'(i);
            w_sel = w_val[i];
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      w_fire    = 1'b0;
      if (clear) begin
         w_next = S_RUN;
      end else begin
         case (r_state)
            S_RUN: begin
               if (w_any) begin
                  w_next    = S_DONE;
                  w_capture = 1'b1;
               end
`ifdef HOST_MONITOR_WATCHDOG_EN
               else if ((stop_limit != 32'h0) && (r_cycles == stop_limit)) begin
                  w_next = S_TIMEOUT;
                  w_fire = 1'b1;
               end
`endif
            end
            default: w_next = r_state;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= S_RUN;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_timeout <= 1'b0;
         r_code    <= 31'h0;
         r_src     <= '0;
         r_cycles  <= 32'h0;
      end else if (clear) begin
         r_state   <= S_RUN;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_timeout <= 1'b0;
         r_code    <= 31'h0;
         r_src     <= '0;
         r_cycles  <= 32'h0;
      end else begin
         r_state <= w_next;
         if (w_capture) begin
            r_done <= 1'b1;
            r_pass <= (w_sel == 32'h1);
            r_code <= w_sel[31:1];
            r_src  <= w_idx;
         end
         if (w_fire) begin
            r_timeout <= 1'b1;
         end
         // The counter freezes on the edge that leaves RUN.
         if ((r_state == S_RUN) && (w_next == S_RUN) && enable &&
             (r_cycles != 32'hFFFF_FFFF)) begin
            r_cycles <= r_cycles + 32'd1;
         end
      end
   end

   assign done    = r_done;
   assign pass    = r_pass;
   assign timeout = r_timeout;
   assign code    = r_code;
   assign src     = r_src;
   assign cycles  = r_cycles;

endmodule

`default_nettype wire

// File: tb/tb_host_monitor.sv
// Bench for host_monitor: a 1-port and a 4-port instance driven with directed
// and random traffic, each checked every cycle against a behavioural model.
`default_nettype none

module tb_host_monitor;

   localparam logic [31:0] H1 = 32'h0000_1000;
   localparam logic [31:0] H4 = 32'h0000_2000;

   logic          clock = 1'b0;
   logic          reset, enable, clear;
   logic [31:0]   stop_limit;

   logic [0:0]    mv1, mr1;
   logic [31:0]   ma1, mw1;
   logic [3:0]    ms1;
   logic [3:0]    mv4, mr4;
   logic [127:0]  ma4, mw4;
   logic [15:0]   ms4;

   logic          d1, p1, t1, d4, p4, t4;
   logic [30:0]   c1, c4;
   logic [0:0]    s1;
   logic [1:0]    s4;
   logic [31:0]   y1, y4;

   int checks = 0;
   int errors = 0;

   // Reference status per instance: index 0 = 1-port, 1 = 4-port.
   bit        m_done [2];
   bit        m_pass [2];
   bit        m_to   [2];
   bit [30:0] m_code [2];
   int        m_src  [2];
   bit [31:0] m_cyc  [2];

   always #5 clock = ~clock;

   host_monitor #(.PORTS(1), .HOST_ADDR(H1)) u_dut1 (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear),
      .stop_limit(stop_limit), .mem_valid(mv1), .mem_ready(mr1),
      .mem_addr(ma1), .mem_wdata(mw1), .mem_wstrb(ms1),
      .done(d1), .pass(p1), .timeout(t1), .code(c1), .src(s1), .cycles(y1));

   host_monitor #(.PORTS(4), .HOST_ADDR(H4)) u_dut4 (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear),
      .stop_limit(stop_limit), .mem_valid(mv4), .mem_ready(mr4),
      .mem_addr(ma4), .mem_wdata(mw4), .mem_wstrb(ms4),
      .done(d4), .pass(p4), .timeout(t4), .code(c4), .src(s4), .cycles(y4));

   task automatic model_zero(input int d);
      m_done[d] = 0; m_pass[d] = 0; m_to[d] = 0;
      m_code[d] = '0; m_src[d] = 0; m_cyc[d] = '0;
   endtask

   // One clock of the spec rules, evaluated on the inputs present at the edge.
   task automatic model_step(input int d, input int np, input logic [31:0] haddr,
                             input logic [3:0] v, input logic [3:0] r,
                             input logic [127:0] a, input logic [127:0] w,
                             input logic [15:0] s);
      logic [31:0] pa, val;
      bit found;
      if (clear) begin
         model_zero(d);
         return;
      end
      if (m_done[d] || m_to[d]) return;
      found = 0;
      for (int p = 0; p < np; p++) begin
         pa = a[32*p +: 32];
         if (!found && v[p] && r[p] && (pa[31:2] == haddr[31:2]) && (s[4*p +: 4] != 4'h0)) begin
            for (int b = 0; b < 4; b++)
               val[8*b +: 8] = s[4*p+b] ? w[32*p+8*b +: 8] : 8'h00;
            found     = 1;
            m_done[d] = 1;
            m_pass[d] = (val == 32'h1);
            m_code[d] = val[31:1];
            m_src[d]  = p;
         end
      end
`ifdef HOST_MONITOR_WATCHDOG_EN
      if (!found && (stop_limit != 0) && (m_cyc[d] == stop_limit)) m_to[d] = 1;
`endif
      if (!m_done[d] && !m_to[d] && enable && (m_cyc[d] != 32'hFFFF_FFFF))
         m_cyc[d] = m_cyc[d] + 1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("done1", 32'(d1), 32'(m_done[0]));
      chk("pass1", 32'(p1), 32'(m_pass[0]));
      chk("timeout1", 32'(t1), 32'(m_to[0]));
      chk("code1", 32'(c1), 32'(m_code[0]));
      chk("src1", 32'(s1), 32'(m_src[0]));
      chk("cycles1", y1, m_cyc[0]);
      chk("done4", 32'(d4), 32'(m_done[1]));
      chk("pass4", 32'(p4), 32'(m_pass[1]));
      chk("timeout4", 32'(t4), 32'(m_to[1]));
      chk("code4", 32'(c4), 32'(m_code[1]));
      chk("src4", 32'(s4), 32'(m_src[1]));
      chk("cycles4", y4, m_cyc[1]);
   endtask

   task automatic tick();
      model_step(0, 1, H1, {3'b0, mv1}, {3'b0, mr1}, {96'b0, ma1}, {96'b0, mw1}, {12'b0, ms1});
      model_step(1, 4, H4, mv4, mr4, ma4, mw4, ms4);
      @(posedge clock);
      #1;
      check_all();
   endtask

   task automatic idle();
      mv1 = '0; mr1 = '0; ma1 = '0; mw1 = '0; ms1 = '0;
      mv4 = '0; mr4 = '0; ma4 = '0; mw4 = '0; ms4 = '0;
      clear = 1'b0;
   endtask

   task automatic st1(input logic v, input logic r, input logic [31:0] a,
                      input logic [31:0] w, input logic [3:0] s);
      mv1 = v; mr1 = r; ma1 = a; mw1 = w; ms1 = s;
   endtask

   task automatic st4(input int p, input logic [31:0] a, input logic [31:0] w,
                      input logic [3:0] s);
      mv4[p] = 1'b1; mr4[p] = 1'b1;
      ma4[32*p +: 32] = a; mw4[32*p +: 32] = w; ms4[4*p +: 4] = s;
   endtask

   task automatic do_clear();
      idle();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      logic [31:0] base;
      idle();
      enable = 1'b0; stop_limit = 32'h0;
      reset = 1'b1;
      model_zero(0); model_zero(1);
      #1 check_all();
      @(posedge clock); #1;
      reset = 1'b0;

      // Counting and idle
      enable = 1'b1;
      repeat (3) tick();
      enable = 1'b0;
      tick();
      enable = 1'b1;

      // Handshake, read and address filtering
      st1(1, 0, H1, 32'h1, 4'hF); tick();
      st1(1, 1, H1, 32'h1, 4'h0); tick();
      st1(1, 1, H1 + 4, 32'h1, 4'hF); tick();
      chk("tp_no_capture", 32'(d1), 32'h0);

      // Passing store on port 0; lowest-index win on the 4-port instance
      idle();
      st1(1, 1, H1, 32'h1, 4'hF);
      st4(1, H4, 32'h5, 4'hF);
      st4(3, H4, 32'h1, 4'hF);
      tick();
      chk("tp_pass", 32'(p1), 32'h1);
      chk("tp_src4", 32'(s4), 32'h1);
      chk("tp_code4", 32'(c4), 32'h2);

      // Sticky: later hits ignored, counter frozen
      idle();
      repeat (2) tick();
      st1(1, 1, H1, 32'h2B, 4'hF); st4(0, H4, 32'h1, 4'hF); tick();

      // Failing code via a non-aligned byte address inside the host word
      do_clear();
      st1(1, 1, H1 + 2, 32'h0000_002B, 4'hF); tick();
      chk("tp_code21", 32'(c1), 32'd21);
      st1(1, 1, H1, 32'h1, 4'hF); tick();

      // Clear coincident with a hit drops the hit
      idle();
      st1(1, 1, H1, 32'h1, 4'hF); st4(2, H4, 32'h1, 4'hF);
      clear = 1'b1; tick();
      idle(); tick();

      // Partial strobe masks the unwritten lanes
      st1(1, 1, H1, 32'hFFFF_FF03, 4'h1); st4(2, H4, 32'hFFFF_0001, 4'h3); tick();
      chk("tp_code1", 32'(c1), 32'h1);

      // Asynchronous reset mid-count
      do_clear();
      repeat (4) tick();
      #2 reset = 1'b1;
      model_zero(0); model_zero(1);
      #1 check_all();
      @(posedge clock); #1;
      reset = 1'b0;
      tick();

      // Watchdog expiry, then a hit landing in the expiry cycle
      stop_limit = 32'd10;
      do_clear();
      repeat (12) tick();
      do_clear();
      repeat (10) tick();
      st1(1, 1, H1, 32'h1, 4'hF); tick();
      chk("tp_hit_beats_timeout", 32'(t1), 32'h0);
      idle(); repeat (2) tick();

      // Lowering the limit below the count never fires
      stop_limit = 32'd0;
      do_clear();
      repeat (8) tick();
      stop_limit = 32'd3;
      repeat (4) tick();

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         idle();
         clear      = ($urandom_range(14) == 0);
         enable     = ($urandom_range(7) != 0);
         stop_limit = ($urandom_range(3) == 0) ? 32'h0 : 32'($urandom_range(40));
         for (int p = 0; p < 5; p++) begin
            logic [31:0] a, w;
            logic [3:0]  s;
            base = (p == 0) ? H1 : H4;
            case ($urandom_range(3))
               0, 1:    a = base + 32'($urandom_range(3));
               2:       a = base + 32'h4;
               default: a = $urandom;
            endcase
            w = ($urandom_range(2) == 0) ? 32'h1 : $urandom;
            s = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom_range(15));
            if (p == 0) begin
               st1($urandom_range(3) != 0, $urandom_range(3) != 0, a, w, s);
            end else if ($urandom_range(2) == 0) begin
               st4(p - 1, a, w, s);
               mv4[p-1] = ($urandom_range(3) != 0);
               mr4[p-1] = ($urandom_range(3) != 0);
            end
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
